sti_serial_receiver: RTL and testbench
======================================

// Module: sti_serial_receiver
// PURPOSE
//  Receive end of the STI serial link: captures so_data/so_valid style bit stream, rebuilds each frame
//  into the original 16-bit parallel word using the sender's length/fill/msb/low settings.
//  Sits at the far end of the STI link (loopback checker, downstream consumer); reports good/bad frames.
// PARAMETERS
//  DATA_W   16  width of recovered parallel word (po_data)
//  MAX_BITS 32  longest legal frame; shift register width
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-low reset
//  cfg_load    in   1      one-cycle pulse: latch cfg_* below
//  cfg_length  in   2      00=8b, 01=16b, 10=24b, 11=32b frame
//  cfg_fill    in   1      24/32b: 1=payload in upper 16 bits of frame, 0=payload in lower 16
//  cfg_msb     in   1      1=first received bit is frame MSB, 0=first bit is LSB
//  cfg_low     in   1      8b frames: 1=byte goes to po_data[7:0], 0=to po_data[15:8]
//  cfg_end     in   1      marks the configured frame as the last one
//  si_data     in   1      serial bit, sampled when si_valid=1
//  si_valid    in   1      high for a contiguous run of bits = one frame
//  po_data     out  DATA_W recovered word; holds until next good frame
//  po_valid    out  1      one-cycle pulse: po_data updated
//  po_err      out  1      one-cycle pulse: frame bit count != configured length
//  frame_cnt   out  8      good frames received, wraps 255->0
//  rx_finish   out  1      sticky: last (cfg_end) frame has completed, good or bad
// BEHAVIOUR
//  - Reset (reset=0 at edge): all outputs 0, config regs 0, FSM->IDLE, shift reg/bit count cleared.
//  - FSM IDLE: si_valid=1 -> RX, bit 0 captured, count=1. cfg_load honoured here, incl. same cycle
//    as first bit (new cfg applies to that frame).
//  - FSM RX: each si_valid=1 cycle captures one bit, count++ (saturates at MAX_BITS+1).
//    si_valid=0 -> CHK. cfg_load in RX or CHK is ignored (no error).
//  - FSM CHK (1 cycle): count==8/16/24/32 per cfg_length -> po_valid=1, po_data loaded,
//    frame_cnt++; else po_err=1, po_data and frame_cnt unchanged. If cfg_end latched -> rx_finish=1.
//    Always -> IDLE. Latency: po_valid/po_err in the cycle after the first si_valid=0.
//  - si_valid=1 during CHK is a new frame start: not captured; bench must leave >=1 idle cycle
//    (IDLE gap of 1 cycle minimum between frames).
//  - Bit placement, L = frame length: msb=1 -> shift left, new bit into [0], frame = sr[L-1:0];
//    msb=0 -> bit k written to sr[k]. Frame word identical for both orders.
//  - Payload: 8b -> low? {8'h00,f[7:0]} : {f[7:0],8'h00}; 16b -> f[15:0];
//    24/32b -> fill? f[L-1:L-16] : f[15:0]. Padding bits are not checked.
//  - Overlong frame (>32 bits): counting saturates, po_err at CHK.
//  - Reset mid-frame: partial frame discarded, no po_err; rx_finish cleared.
//  - rx_finish clears only on reset.
// STRUCTURE
//  - sti_pkg: frame length encodings (LEN_8..LEN_32), len_to_bits function, FSM state enum.
//  - Sub-module sti_rx_shifter: 32b shift/indexed-write register + bit counter; top holds FSM,
//    config latch, payload extraction, counters.
// TESTING
//  - 16b msb-first, send 0xA5C3 -> po_data=16'hA5C3, po_valid 1 cycle after si_valid falls, frame_cnt=1.
//  - 8b lsb-first, low=0, bits of 0x3C -> po_data=16'h3C00; repeat low=1 -> 16'h003C, frame_cnt=2.
//  - 32b msb-first fill=1 frame 32'h1234_0000 -> 16'h1234; fill=0 frame 32'h0000_BEEF -> 16'hBEEF.
//  - 16b cfg, send 15 bits -> po_err pulse, po_data keeps prior value, frame_cnt unchanged;
//    send 40 bits -> po_err.
//  - cfg_end=1 with a 24b fill=0 frame 24'h00_ABCD -> po_data=16'hABCD, rx_finish=1 and stays 1.
//  - reset=0 after 10 bits of a frame -> all outputs 0; next clean 16b 0x5A5A -> po_data=16'h5A5A, frame_cnt=1.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial receiver: frame length codes,
// receive FSM states and the length-to-bit-count helper.
package sti_pkg;

  typedef enum logic [1:0] {
    LEN_8  = 2'b00,
    LEN_16 = 2'b01,
    LEN_24 = 2'b10,
    LEN_32 = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RX   = 2'b01,
    ST_CHK  = 2'b10
  } state_e;

  // Number of serial bits in a legal frame of the given length code.
  function automatic logic [5:0] len_to_bits(input len_e len);
    return ({4'b0000, len} + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/sti_rx_shifter.sv
// Frame assembly register: shift-left (msb-first) or indexed write (lsb-first),
// plus a bit counter that saturates one past the longest legal frame.
module sti_rx_shifter #(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = $clog2(MAX_BITS + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic                i_msb,
  output logic [MAX_BITS-1:0] o_sr,
  output logic [CNT_W-1:0]    o_count
);

  localparam int IDX_W = $clog2(MAX_BITS);

  logic [MAX_BITS-1:0] r_sr;
  logic [CNT_W-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (i_start) begin
      // First bit lands in [0] for both orders, so no order select is needed here.
      r_sr    <= {{(MAX_BITS-1){1'b0}}, i_bit};
      r_count <= CNT_W'(1);
    end else if (i_shift) begin
      if (i_msb) begin
        r_sr <= {r_sr[MAX_BITS-2:0], i_bit};
      end else if (r_count < CNT_W'(MAX_BITS)) begin
        r_sr[r_count[IDX_W-1:0]] <= i_bit;
      end
      if (r_count != CNT_W'(MAX_BITS + 1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_sr    = r_sr;
  assign o_count = r_count;

endmodule

// File: rtl/sti_serial_receiver.sv
// STI link receive end: rebuilds serial frames into 16-bit words and flags bad frames.
//   state   | meaning
//   ST_IDLE | waiting for si_valid; cfg_load accepted; first bit captured on entry to RX
//   ST_RX   | one bit per si_valid cycle; si_valid low ends the frame and registers the result
//   ST_CHK  | result visible (po_valid/po_err pulse); si_valid ignored; back to IDLE
module sti_serial_receiver
  import sti_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_fill,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  input  logic              cfg_end,
  input  logic              si_data,
  input  logic              si_valid,
  output logic [DATA_W-1:0] po_data,
  output logic              po_valid,
  output logic              po_err,
  output logic [7:0]        frame_cnt,
  output logic              rx_finish
);

  localparam int CNT_W = $clog2(MAX_BITS + 2);

  state_e r_state, w_state_nx;
  logic   w_start, w_shift, w_done, w_cfg_take;

  len_e   r_len;
  logic   r_fill, r_msb, r_low, r_end;

  logic [MAX_BITS-1:0] w_sr;
  logic [CNT_W-1:0]    w_count;
  logic [DATA_W-1:0]   w_payload;
  logic                w_good;

  logic [DATA_W-1:0]   r_po_data;
  logic                r_po_valid, r_po_err, r_rx_finish;
  logic [7:0]          r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_done     = 1'b0;
    w_cfg_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_take = cfg_load;
        if (si_valid) begin
          w_start    = 1'b1;
          w_state_nx = ST_RX;
        end
      end
      ST_RX: begin
        if (si_valid) begin
          w_shift = 1'b1;
        end else begin
          w_done     = 1'b1;
          w_state_nx = ST_CHK;
        end
      end
      ST_CHK:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Config latched in IDLE only; a load alongside the first bit governs that frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len  <= LEN_8;
      r_fill <= 1'b0;
      r_msb  <= 1'b0;
      r_low  <= 1'b0;
      r_end  <= 1'b0;
    end else if (w_cfg_take) begin
      r_len  <= len_e'(cfg_length);
      r_fill <= cfg_fill;
      r_msb  <= cfg_msb;
      r_low  <= cfg_low;
      r_end  <= cfg_end;
    end
  end

  sti_rx_shifter #(
    .MAX_BITS (MAX_BITS),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_shift (w_shift),
    .i_bit   (si_data),
    .i_msb   (r_msb),
    .o_sr    (w_sr),
    .o_count (w_count)
  );

  always_comb begin
    w_payload = '0;
    case (r_len)
      LEN_8:   w_payload = r_low ? {8'h00, w_sr[7:0]} : {w_sr[7:0], 8'h00};
      LEN_16:  w_payload = w_sr[15:0];
      LEN_24:  w_payload = r_fill ? w_sr[23:8]  : w_sr[15:0];
      LEN_32:  w_payload = r_fill ? w_sr[31:16] : w_sr[15:0];
      default: w_payload = '0;
    endcase
  end

  assign w_good = (w_count == len_to_bits(r_len));

  // Results register on the RX->CHK edge so they are visible during CHK.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_po_data   <= '0;
      r_po_valid  <= 1'b0;
      r_po_err    <= 1'b0;
      r_frame_cnt <= '0;
      r_rx_finish <= 1'b0;
    end else begin
      r_po_valid <= 1'b0;
      r_po_err   <= 1'b0;
      if (w_done) begin
        if (w_good) begin
          r_po_valid  <= 1'b1;
          r_po_data   <= w_payload;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_po_err <= 1'b1;
        end
        if (r_end) r_rx_finish <= 1'b1;
      end
    end
  end

  assign po_data   = r_po_data;
  assign po_valid  = r_po_valid;
  assign po_err    = r_po_err;
  assign frame_cnt = r_frame_cnt;
  assign rx_finish = r_rx_finish;

endmodule

// File: tb/tb_sti_serial_receiver.sv
// Scoreboard bench for sti_serial_receiver: directed frames followed by randomized
// frames, expectations derived from frame values and the configured framing rules.
module tb_sti_serial_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_length = 2'b00;
  logic        cfg_fill = 1'b0, cfg_msb = 1'b0, cfg_low = 1'b0, cfg_end = 1'b0;
  logic        si_data = 1'b0, si_valid = 1'b0;
  logic [15:0] po_data;
  logic        po_valid, po_err, rx_finish;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  sti_serial_receiver #(.DATA_W(16), .MAX_BITS(32)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
    .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low), .cfg_end(cfg_end),
    .si_data(si_data), .si_valid(si_valid), .po_data(po_data), .po_valid(po_valid),
    .po_err(po_err), .frame_cnt(frame_cnt), .rx_finish(rx_finish)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          err;
    logic [7:0]  cnt;
    bit          fin;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_len;
  bit          m_fill, m_msb, m_low, m_end;
  logic [15:0] m_data;
  logic [7:0]  m_cnt;
  bit          m_fin;
  // configuration to be loaded next
  int          nx_len;
  bit          nx_fill, nx_msb, nx_low, nx_end;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] payload(input logic [31:0] f);
    if (m_len == 8)       return m_low ? {8'h00, f[7:0]} : {f[7:0], 8'h00};
    else if (m_len == 16) return f[15:0];
    else if (m_fill)      return 16'(f >> (m_len - 16));
    else                  return f[15:0];
  endfunction

  task automatic model_reset();
    m_len = 8; m_fill = 0; m_msb = 0; m_low = 0; m_end = 0;
    m_data = '0; m_cnt = '0; m_fin = 0;
  endtask

  task automatic model_apply();
    m_len = nx_len; m_fill = nx_fill; m_msb = nx_msb; m_low = nx_low; m_end = nx_end;
  endtask

  task automatic drive_cfg_pins();
    cfg_length = 2'(nx_len / 8 - 1);
    cfg_fill = nx_fill; cfg_msb = nx_msb; cfg_low = nx_low; cfg_end = nx_end;
  endtask

  task automatic set_next(input int len, input bit fill, input bit msb, input bit low, input bit e);
    nx_len = len; nx_fill = fill; nx_msb = msb; nx_low = low; nx_end = e;
  endtask

  task automatic do_cfg();
    @(posedge clk); #1;
    drive_cfg_pins();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    model_apply();
  endtask

  // Sends n bits; for n<=32 they are the low n bits of f in the configured order.
  task automatic send_frame(input logic [31:0] f, input int n, input bit ld);
    exp_t e;
    bit   b;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0 && ld) begin
        drive_cfg_pins();
        cfg_load = 1'b1;
        model_apply();
      end else begin
        cfg_load = 1'b0;
      end
      if (n <= 32) b = m_msb ? f[n-1-k] : f[k];
      else         b = 1'($urandom);
      si_valid = 1'b1;
      si_data  = b;
    end
    @(posedge clk); #1;
    si_valid = 1'b0; si_data = 1'b0; cfg_load = 1'b0;
    if (n == m_len) begin
      m_data = payload(f);
      m_cnt  = m_cnt + 8'd1;
    end
    if (m_end) m_fin = 1;
    e.cyc = cyc + 1; e.data = m_data; e.err = (n != m_len); e.cnt = m_cnt; e.fin = m_fin;
    sbq.push_back(e);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; si_valid = 1'b0; cfg_load = 1'b0;
    @(posedge clk); #1;
    chk("reset_po_data", 32'(po_data), 0);
    chk("reset_po_valid", 32'(po_valid), 0);
    chk("reset_po_err", 32'(po_err), 0);
    chk("reset_frame_cnt", 32'(frame_cnt), 0);
    chk("reset_rx_finish", 32'(rx_finish), 0);
    reset = 1'b1;
    model_reset();
    sbq.delete();
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset && (po_valid || po_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid:%0b err:%0b required=no output", po_valid, po_err);
      end else begin
        e = sbq.pop_front();
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
        chk("po_valid", 32'(po_valid), 32'(!e.err));
        chk("po_err", 32'(po_err), 32'(e.err));
        chk("po_data", 32'(po_data), 32'(e.data));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        chk("rx_finish", 32'(rx_finish), 32'(e.fin));
      end
    end
  end

  initial begin
    int L, n, mode, w;
    logic [31:0] f;
    model_reset();
    set_next(8, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    do_reset();

    // reset configuration: 8b, lsb-first, byte to upper half
    send_frame(32'h5A, 8, 0);

    set_next(16, 0, 1, 0, 0); do_cfg(); send_frame(32'hA5C3, 16, 0);
    set_next(8, 0, 0, 0, 0);  do_cfg(); send_frame(32'h3C, 8, 0);
    set_next(8, 0, 0, 1, 0);  do_cfg(); send_frame(32'h3C, 8, 0);
    set_next(32, 1, 1, 0, 0); do_cfg(); send_frame(32'h1234_0000, 32, 0);
    set_next(32, 0, 1, 0, 0); do_cfg(); send_frame(32'h0000_BEEF, 32, 0);
    set_next(16, 0, 1, 0, 0); do_cfg(); send_frame(32'h1357, 15, 0);
    send_frame(32'h0, 40, 0);
    set_next(24, 0, 1, 0, 1); do_cfg(); send_frame(32'h00_ABCD, 24, 0);
    set_next(16, 0, 0, 0, 0); do_cfg(); send_frame(32'h6E21, 16, 0);
    // new config on the same cycle as the first bit
    set_next(24, 1, 0, 0, 0); send_frame(32'hC0FFEE, 24, 1);

    // reset in the middle of a frame
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      si_valid = 1'b1; si_data = 1'($urandom);
    end
    do_reset();
    set_next(16, 0, 1, 0, 0); do_cfg(); send_frame(32'h5A5A, 16, 0);

    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 2);
      if (mode != 0) begin
        set_next(8 * $urandom_range(1, 4), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0));
        L = nx_len;
      end else begin
        L = m_len;
      end
      if ($urandom_range(0, 5) == 0) n = $urandom_range(1, 40);
      else                           n = L;
      f = $urandom;
      if (mode == 1) begin
        do_cfg();
        send_frame(f, n, 0);
      end else begin
        send_frame(f, n, mode == 2);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
